// File: rtl/dds_pkg.sv
// Shared definitions for the DDS waveform generator: wave codes, amplitude width, midscale helper.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package dds_pkg;

    localparam logic [2:0] WAVE_SINE   = 3'd0;
    localparam logic [2:0] WAVE_SQUARE = 3'd1;
    localparam logic [2:0] WAVE_TRI    = 3'd2;
    localparam logic [2:0] WAVE_SAW    = 3'd3;
    localparam logic [2:0] WAVE_DC     = 3'd4;

    localparam int AMP_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Offset-binary zero code for a DAC of the given width.
    function automatic int mid(input int dac_w);
        return 1 << (dac_w - 1);
    endfunction

endpackage

// File: rtl/dds_sine_rom.sv
// Full-wave signed sine table, 2^LUT_AW entries, peak +/-(2^(DAC_W-1)-1).
// Latency: 1 clk (registered output).
// Backpressure: none; reads every cycle.
module dds_sine_rom
    import dds_pkg::*;
#(
    parameter int DAC_W  = 8,
    parameter int LUT_AW = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [LUT_AW-1:0]       addr,
    output logic signed [DAC_W-1:0] data
);

    localparam int  DEPTH = 1 << LUT_AW;
    localparam real PI    = 3.14159265358979323846;
    localparam real PEAK  = $itor(mid(DAC_W) - 1);

    logic signed [DAC_W-1:0] table_w [DEPTH];
    logic signed [DAC_W-1:0] data_d;
    logic signed [DAC_W-1:0] data_q;

    // Table contents are fixed at elaboration; rounding is half away from zero.
    for (genvar i = 0; i < DEPTH; i++) begin : g_table
        localparam real ANG  = 2.0 * PI * $itor(i) / $itor(DEPTH);
        localparam real VAL  = PEAK * $sin(ANG);
        localparam int  CODE = (VAL >= 0.0) ? $rtoi(VAL + 0.5) : -$rtoi(0.5 - VAL);
        assign table_w[i] = CODE[DAC_W-1:0];
    end

    // Table lookup for the registered read port.
    always_comb begin
        data_d = table_w[addr];
    end

    // Read register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_q <= '0;
        else        data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/dds_wavegen.sv
// DDS waveform generator: phase accumulator -> sine ROM / shaper -> amplitude scale -> offset-binary DAC.
// Latency: 3 clk from the phase register to dac_da (phase/ROM, shape, scale/output).
// Backpressure: cfg_ready drops while a run-time config waits for the next phase wrap.
module dds_wavegen
    import dds_pkg::*;
#(
    parameter int DAC_W   = 8,
    parameter int PHASE_W = 32,
    parameter int LUT_AW  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [2:0]         cfg_wave,
    input  logic [PHASE_W-1:0] cfg_ftw,
    input  logic [AMP_W-1:0]   cfg_amp,
    input  logic               enable,
    output logic [DAC_W-1:0]   dac_da,
    output logic               dac_clka,
    output logic               dac_wra,
    output logic               dac_sleep,
    output logic               dac_mode,
    output logic               sample_valid
);

    localparam logic [DAC_W-1:0] MID = DAC_W'(mid(DAC_W));
    localparam int               PW  = DAC_W + AMP_W + 2;

    typedef struct packed {
        logic [2:0]         wave;
        logic [PHASE_W-1:0] ftw;
        logic [AMP_W-1:0]   amp;
    } cfg_t;

    state_t             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               pend_q, pend_d;
    logic               cfg_ready_q, cfg_ready_d;
    cfg_t               cfg_act_q, cfg_act_d;
    cfg_t               cfg_pend_q, cfg_pend_d;
    cfg_t               cfg_in;
    logic [PHASE_W:0]   sum;
    logic               accept;
    logic               run_next;

    logic                    s1_vld_q, s1_vld_d;
    logic [DAC_W-1:0]        s1_top_q, s1_top_d;
    logic [2:0]              s1_wave_q, s1_wave_d;
    logic [AMP_W-1:0]        s1_amp_q, s1_amp_d;
    logic signed [DAC_W-1:0] rom_dat;
    logic [DAC_W-1:0]        dbl, fold;
    logic signed [DAC_W-1:0] shape;
    logic                    s2_vld_q, s2_vld_d;
    logic signed [DAC_W-1:0] s2_s_q, s2_s_d;
    logic [AMP_W-1:0]        s2_amp_q, s2_amp_d;
    logic signed [AMP_W+1:0] gain;
    logic signed [PW-1:0]    prod;
    logic                    vld_q, vld_d;
    logic [DAC_W-1:0]        dac_q, dac_d;
    logic                    sleep_q, sleep_d;

    assign cfg_in = '{wave: cfg_wave, ftw: cfg_ftw, amp: cfg_amp};

    // Run/idle control, accumulator, and the config hand-over that only happens on a phase wrap.
    always_comb begin
        sum        = {1'b0, phase_q} + {1'b0, cfg_act_q.ftw};
        accept     = cfg_valid && cfg_ready_q;
        state_d    = state_q;
        phase_d    = '0;
        pend_d     = pend_q;
        cfg_act_d  = cfg_act_q;
        cfg_pend_d = cfg_pend_q;
        case (state_q)
            ST_IDLE: if (enable)  state_d = ST_RUN;
            ST_RUN:  if (!enable) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (state_q == ST_IDLE) begin
            pend_d = 1'b0;
            if (accept) cfg_act_d = cfg_in;
        end else begin
            if (enable) phase_d = sum[PHASE_W-1:0];
            if (accept) begin
                // A stopped accumulator never wraps, and a falling enable ends the run: take it now.
                if (!enable || cfg_act_q.ftw == '0) begin
                    cfg_act_d = cfg_in;
                end else begin
                    pend_d     = 1'b1;
                    cfg_pend_d = cfg_in;
                end
            end else if (pend_q && (sum[PHASE_W] || !enable)) begin
                cfg_act_d = cfg_pend_q;
                pend_d    = 1'b0;
            end
        end
        cfg_ready_d = (state_d == ST_IDLE) || !pend_d;
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            pend_q      <= 1'b0;
            cfg_ready_q <= 1'b0;
            cfg_act_q   <= '{wave: WAVE_SINE, ftw: '0, amp: '1};
            cfg_pend_q  <= '{wave: WAVE_SINE, ftw: '0, amp: '1};
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            pend_q      <= pend_d;
            cfg_ready_q <= cfg_ready_d;
            cfg_act_q   <= cfg_act_d;
            cfg_pend_q  <= cfg_pend_d;
        end
    end

    dds_sine_rom #(
        .DAC_W  (DAC_W),
        .LUT_AW (LUT_AW)
    ) u_rom (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (phase_q[PHASE_W-1 -: LUT_AW]),
        .data  (rom_dat)
    );

    // Sample pipeline; wave/amp travel with the phase so a switch lands exactly on the wrap sample.
    always_comb begin
        run_next  = (state_q == ST_RUN) && (state_d == ST_RUN);
        s1_vld_d  = run_next;
        s1_top_d  = phase_q[PHASE_W-1 -: DAC_W];
        s1_wave_d = cfg_act_q.wave;
        s1_amp_d  = cfg_act_q.amp;
        dbl       = {s1_top_q[DAC_W-2:0], 1'b0};
        fold      = s1_top_q[DAC_W-1] ? ~dbl : dbl;
        case (s1_wave_q)
            WAVE_SINE:   shape = rom_dat;
            WAVE_SQUARE: shape = s1_top_q[DAC_W-1] ? {1'b1, {(DAC_W-1){1'b0}}}
                                                   : {1'b0, {(DAC_W-1){1'b1}}};
            WAVE_TRI:    shape = $signed(fold - MID);
            WAVE_SAW:    shape = $signed(s1_top_q - MID);
            WAVE_DC:     shape = '0;
            default:     shape = '0;
        endcase
        s2_vld_d = s1_vld_q && run_next;
        s2_s_d   = shape;
        s2_amp_d = s1_amp_q;
        gain     = $signed({2'b00, s2_amp_q} + (AMP_W+2)'(1));
        prod     = PW'(s2_s_q) * PW'(gain);
        vld_d    = s2_vld_q && run_next;
        dac_d    = vld_d ? DAC_W'(prod >>> AMP_W) + MID : MID;
        sleep_d  = (state_d == ST_IDLE);
    end

    // Pipeline registers; leaving RUN flushes them to midscale/invalid in the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_top_q  <= '0;
            s1_wave_q <= WAVE_SINE;
            s1_amp_q  <= '1;
            s2_vld_q  <= 1'b0;
            s2_s_q    <= '0;
            s2_amp_q  <= '1;
            vld_q     <= 1'b0;
            dac_q     <= MID;
            sleep_q   <= 1'b1;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_top_q  <= s1_top_d;
            s1_wave_q <= s1_wave_d;
            s1_amp_q  <= s1_amp_d;
            s2_vld_q  <= s2_vld_d;
            s2_s_q    <= s2_s_d;
            s2_amp_q  <= s2_amp_d;
            vld_q     <= vld_d;
            dac_q     <= dac_d;
            sleep_q   <= sleep_d;
        end
    end

    assign cfg_ready    = cfg_ready_q;
    assign dac_da       = dac_q;
    assign sample_valid = vld_q;
    assign dac_sleep    = sleep_q;
    assign dac_mode     = 1'b1;
    assign dac_clka     = ~clk;
    assign dac_wra      = ~clk;

endmodule
